mem_access_unit: RTL and testbench

Load/store front-end between the MEM pipeline stage and the word-addressed data memory. It accepts one byte, halfword or word access at a time and rejects misaligned or out-of-range addresses. It performs sub-word stores as read-modify-write and returns sign- or zero-extended load data. All memory-side strobes, addresses and data are driven from registers, so the level-sensitive memory always sees glitch-free, single-cycle strobes.

---
 rtl/mau_pkg.sv | 32 +++
 rtl/mau_if.sv | 25 ++
 rtl/mau_lane_align.sv | 56 +++++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// Shared encodings, FSM state type and request error check for the memory access unit.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned MEM_WORDS_DEFAULT = 1024;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StRsp
    } mau_state_e;

    // Misaligned, illegal size, or word index beyond the end of memory.
    function automatic logic req_error(logic [1:0] size, logic [31:0] addr,
                                       int unsigned words);
        logic misaligned;
        logic out_of_range;
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr[0];
            SZ_WORD: misaligned = |addr[1:0];
            default: misaligned = 1'b1;
        endcase
        out_of_range = {2'b00, addr[31:2]} >= words;
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/mau_if.sv
// Pipeline-side request/response bundle; master is the MEM stage, slave is the access unit.
interface mau_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mau_lane_align.sv
// Little-endian lane handling: load extract with sign/zero extension and store lane merge.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SZ_BYTE: load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_o = {{16{signed_i & half_sel[15]}}, half_sel};
            default: load_o = rdata_i;
        endcase
    end

    always_comb begin
        merge_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                unique case (addr_lo_i)
                    2'd0: merge_o[7:0]   = wdata_i[7:0];
                    2'd1: merge_o[15:8]  = wdata_i[7:0];
                    2'd2: merge_o[23:16] = wdata_i[7:0];
                    2'd3: merge_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo_i[1]) begin
                    merge_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_o[15:0] = wdata_i[15:0];
                end
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: FSM, request latches and registered memory strobes/response.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    mau_if.slave        bus,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    mau_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [31:0] load_data;
    logic [31:0] merge_data;

    mau_lane_align u_lane_align (
        .rdata_i  (mem_rdata_i),
        .addr_lo_i(addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        signed_d    = signed_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d     = bus.req_addr;
                    size_d     = bus.req_size;
                    signed_d   = bus.req_signed;
                    write_d    = bus.req_write;
                    wdata_d    = bus.req_wdata;
                    mem_addr_d = {bus.req_addr[31:2], 2'b00};
                    if (req_error(bus.req_size, bus.req_addr, MEM_WORDS)) begin
                        state_d     = StRsp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (bus.req_write && bus.req_size == SZ_WORD) begin
                        state_d     = StWr;
                        mem_write_d = 1'b1;
                        mem_wdata_d = bus.req_wdata;
                    end else begin
                        state_d    = StRd;
                        mem_read_d = 1'b1;
                    end
                end
            end
            StRd: begin
                // Only sub-word stores reach RD with write set; they merge into the read word.
                if (write_q) begin
                    state_d     = StWr;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merge_data;
                end else begin
                    state_d     = StRsp;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data;
                end
            end
            StWr: begin
                state_d     = StRsp;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
            end
            StRsp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = rst_n && (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign mem_read_o    = mem_read_q;
    assign mem_write_o   = mem_write_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [1024];

    int checks   = 0;
    int failures = 0;
    int n_rd, n_wr, n_rsp, overlaps;

    mau_if bus ();

    mem_access_unit #(.MEM_WORDS(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .mem_read_o (mem_read),
        .mem_write_o(mem_write),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: sample at the falling edge and let the memory model commit writes.
    task automatic tick();
        @(negedge clk);
        if (mem_read) n_rd++;
        if (mem_write) begin
            n_wr++;
            mem[mem_addr[11:2]] = mem_wdata;
        end
        if (bus.rsp_valid) n_rsp++;
        if (mem_read && mem_write) overlaps++;
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 10 && !bus.req_ready; i++) @(negedge clk);
        chk({name, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        logic        err;
        logic [31:0] rdata;
        mem[4] = v.init;
        @(negedge clk);
        drive(v.wr, v.sz, v.sgn, v.addr, v.wdata);
        wait_ready(v.name);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n_rd = 0; n_wr = 0; n_rsp = 0;
        lat = 0; err = 1'bx; rdata = 'x;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (bus.rsp_valid) begin
                lat   = c;
                err   = bus.rsp_err;
                rdata = bus.rsp_rdata;
                break;
            end
        end
        chk({v.name, "_lat"}, lat, v.exp_lat);
        chk({v.name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
        chk({v.name, "_rdata"}, rdata, v.exp_rdata);
        chk({v.name, "_nrd"}, n_rd, v.exp_rd);
        chk({v.name, "_nwr"}, n_wr, v.exp_wr);
        chk({v.name, "_mem"}, mem[4], v.exp_mem);
    endtask

    initial begin
        logic [3:0] obs;
        logic [3:0] exp_seq [6];

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        n_rd = 0; n_wr = 0; n_rsp = 0; overlaps = 0;
        bus.req_valid = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;

        // name wr sz sgn addr wdata init exp_rdata err lat rd wr exp_mem
        vecs[0]  = '{"lw",     0, 2'b10, 0, 32'h10,   0,          32'h11223344,
                     32'h11223344, 0, 2, 1, 0, 32'h11223344};
        vecs[1]  = '{"lb_s",   0, 2'b00, 1, 32'h13,   0,          32'h80223344,
                     32'hFFFFFF80, 0, 2, 1, 0, 32'h80223344};
        vecs[2]  = '{"lbu",    0, 2'b00, 0, 32'h13,   0,          32'h80223344,
                     32'h00000080, 0, 2, 1, 0, 32'h80223344};
        vecs[3]  = '{"lh_s",   0, 2'b01, 1, 32'h12,   0,          32'h80223344,
                     32'hFFFF8022, 0, 2, 1, 0, 32'h80223344};
        vecs[4]  = '{"lhu",    0, 2'b01, 0, 32'h10,   0,          32'h80223344,
                     32'h00003344, 0, 2, 1, 0, 32'h80223344};
        vecs[5]  = '{"sb",     1, 2'b00, 0, 32'h11,   32'hFFFFFFAB, 32'h11223344,
                     32'h0, 0, 3, 1, 1, 32'h1122AB44};
        vecs[6]  = '{"sh",     1, 2'b01, 0, 32'h12,   32'h0000BEEF, 32'h11223344,
                     32'h0, 0, 3, 1, 1, 32'hBEEF3344};
        vecs[7]  = '{"sw",     1, 2'b10, 0, 32'h10,   32'hCAFEBABE, 32'h11223344,
                     32'h0, 0, 2, 0, 1, 32'hCAFEBABE};
        vecs[8]  = '{"lb_pos", 0, 2'b00, 1, 32'h10,   0,          32'h80223344,
                     32'h00000044, 0, 2, 1, 0, 32'h80223344};
        vecs[9]  = '{"lw_mis", 0, 2'b10, 0, 32'h12,   0,          32'h11223344,
                     32'h0, 1, 1, 0, 0, 32'h11223344};
        vecs[10] = '{"sw_oor", 1, 2'b10, 0, 32'h1000, 32'hDEADBEEF, 32'h11223344,
                     32'h0, 1, 1, 0, 0, 32'h11223344};
        vecs[11] = '{"sz11",   0, 2'b11, 0, 32'h10,   0,          32'h11223344,
                     32'h0, 1, 1, 0, 0, 32'h11223344};
        vecs[12] = '{"lh_mis", 0, 2'b01, 0, 32'h11,   0,          32'h11223344,
                     32'h0, 1, 1, 0, 0, 32'h11223344};

        #3;
        chk("rst_strobes", {28'd0, mem_read, mem_write, bus.rsp_valid, bus.rsp_err}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Reset while a byte store is in its read cycle.
        mem[4] = 32'h11223344;
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB);
        wait_ready("mid_rst");
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n_rd = 0; n_wr = 0; n_rsp = 0;
        tick();
        chk("mid_rst_rd_before", {31'd0, mem_read}, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_rd_drop", {30'd0, mem_read, mem_write}, 32'd0);
        n_rd = 0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_rst_nwr", n_wr, 0);
        chk("mid_rst_nrsp", n_rsp, 0);
        chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("mid_rst_mem", mem[4], 32'h11223344);

        // Back-to-back: lw held, then sw accepted in the IDLE cycle after the first RSP.
        // Per cycle {ready, rsp_valid, mem_read, mem_write}.
        exp_seq[0] = 4'b0010;
        exp_seq[1] = 4'b0100;
        exp_seq[2] = 4'b1000;
        exp_seq[3] = 4'b0001;
        exp_seq[4] = 4'b0100;
        exp_seq[5] = 4'b1000;
        mem[4] = 32'h11223344;
        mem[5] = 32'h0;
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        wait_ready("b2b");
        @(posedge clk);
        #1 drive(1'b1, 2'b10, 1'b0, 32'h14, 32'h55AA1234);
        for (int c = 1; c <= 6; c++) begin
            tick();
            obs = {bus.req_ready, bus.rsp_valid, mem_read, mem_write};
            chk($sformatf("b2b_cyc%0d", c), {28'd0, obs}, {28'd0, exp_seq[c-1]});
            if (c == 2) chk("b2b_lw_rdata", bus.rsp_rdata, 32'h11223344);
            if (c == 4) begin
                chk("b2b_sw_wdata", mem_wdata, 32'h55AA1234);
                chk("b2b_sw_addr", mem_addr, 32'h14);
                bus.req_valid = 1'b0;
            end
        end
        chk("b2b_mem5", mem[5], 32'h55AA1234);
        chk("no_overlap", overlaps, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
